// File: rtl/tlast_gen_s00_axil_slave_if.sv
// AXI4-Lite bus bundle between the S00_AXI master and the tlast_gen register slave.
// Clock and reset travel as plain ports on the modules, not through this bundle.
interface tlast_gen_s00_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/tlast_gen_s00_axil_slave.sv
// AXI4-Lite slave holding the four tlast_gen control registers, with independent
// AW/W holding buffers, byte-strobed commits and a one-cycle write strobe per register.
module tlast_gen_s00_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    tlast_gen_s00_axil_slave_if.slave     s00_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg3,
    output logic [3:0]                    reg_wr_stb
);
    localparam int NUM_REGS = 4;
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

    typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;
    typedef logic [1:0]                    idx_t;

    logic                aw_full_q, aw_full_d;
    idx_t                aw_idx_q,  aw_idx_d;
    logic                w_full_q,  w_full_d;
    word_t               w_data_q,  w_data_d;
    logic [STRB_W-1:0]   w_strb_q,  w_strb_d;
    logic                bvalid_q,  bvalid_d;
    logic                rvalid_q,  rvalid_d;
    word_t               rdata_q,   rdata_d;
    word_t               slv_reg_q [NUM_REGS];
    word_t               slv_reg_d [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_stb_q, reg_wr_stb_d;

    logic aw_hs, w_hs, ar_hs, commit;
    idx_t ar_idx;
    logic unused_bits;

    // Readies are gated by the reset input so they read 0 for as long as reset is held.
    assign s00_axi.awready = !aw_full_q && !s00_axi_areset;
    assign s00_axi.wready  = !w_full_q  && !s00_axi_areset;
    assign s00_axi.arready = !rvalid_q  && !s00_axi_areset;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;

    assign slv_reg0   = slv_reg_q[0];
    assign slv_reg1   = slv_reg_q[1];
    assign slv_reg2   = slv_reg_q[2];
    assign slv_reg3   = slv_reg_q[3];
    assign reg_wr_stb = reg_wr_stb_q;

    assign aw_hs  = s00_axi.awvalid && s00_axi.awready;
    assign w_hs   = s00_axi.wvalid  && s00_axi.wready;
    assign ar_hs  = s00_axi.arvalid && s00_axi.arready;
    assign commit = aw_full_q && w_full_q && (!bvalid_q || s00_axi.bready);
    assign ar_idx = s00_axi.araddr[3:2];

    // Protection bits and the byte/alias address bits carry no meaning here.
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr, s00_axi.araddr};

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path can infer a latch.
        aw_full_d    = aw_full_q;
        aw_idx_d     = aw_idx_q;
        w_full_d     = w_full_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        slv_reg_d    = slv_reg_q;
        reg_wr_stb_d = '0;

        // awready/wready are low while a buffer is full, so a load never meets a commit.
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s00_axi.awaddr[3:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s00_axi.wdata;
            w_strb_d = s00_axi.wstrb;
        end

        if (commit) begin
            aw_full_d              = 1'b0;
            w_full_d               = 1'b0;
            bvalid_d               = 1'b1;
            reg_wr_stb_d[aw_idx_q] = 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) slv_reg_d[aw_idx_q][8*b +: 8] = w_data_q[8*b +: 8];
            end
        end else if (bvalid_q && s00_axi.bready) begin
            bvalid_d = 1'b0;
        end

        // Reads sample the registered contents, so a same-edge commit is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = slv_reg_q[ar_idx];
        end else if (rvalid_q && s00_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            reg_wr_stb_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) slv_reg_q[k] <= '0;
        end else begin
            aw_full_q    <= aw_full_d;
            w_full_q     <= w_full_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            reg_wr_stb_q <= reg_wr_stb_d;
            slv_reg_q    <= slv_reg_d;
        end
    end

    // NOTE: buffer payloads are left out of reset; they are only consumed while their full flag is set.
    always_ff @(posedge s00_axi_aclk) begin
        aw_idx_q <= aw_idx_d;
        w_data_q <= w_data_d;
        w_strb_q <= w_strb_d;
    end
endmodule
